// File: rtl/reg_writeback_queue.sv
// Ordered write-back queue between the ALU/load result paths and the register file write port.
// Drains one entry per clock and offers newest-value forwarding for three lookup ports.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          btn,
    input  logic          Rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_dat,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_reg,
    input  logic [DW-1:0] ld_dat,
    output logic          in_ready,
    output logic          RegWrite,
    output logic [AW-1:0] regW,
    output logic [DW-1:0] Wdat,
    input  logic [AW-1:0] regA,
    input  logic [AW-1:0] regB,
    input  logic [AW-1:0] regC,
    output logic          hitA,
    output logic          hitB,
    output logic          hitC,
    output logic [DW-1:0] fwdA,
    output logic [DW-1:0] fwdB,
    output logic [DW-1:0] fwdC
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] r_reg_q;
    logic [DEPTH-1:0][DW-1:0] r_dat_q;
    logic [PW-1:0]            r_rp;
    logic [PW-1:0]            r_wp;
    logic [CW-1:0]            r_count;
    logic                     r_regwrite;
    logic [AW-1:0]            r_regw;
    logic [DW-1:0]            r_wdat;

    logic                     w_alu_en;
    logic                     w_ld_en;
    logic                     w_pop;
    logic [CW-1:0]            w_enq_cnt;
    logic [PW-1:0]            w_ld_ptr;
    logic [DW:0]              w_fa;
    logic [DW:0]              w_fb;
    logic [DW:0]              w_fc;

    // Output stage is searched first, then entries oldest to newest, so the last match wins.
    function automatic logic [DW:0] fwd_lookup(
        input logic [AW-1:0]            addr,
        input logic [DEPTH-1:0][AW-1:0] regs,
        input logic [DEPTH-1:0][DW-1:0] dats,
        input logic [PW-1:0]            rp,
        input logic [CW-1:0]            cnt,
        input logic                     ow,
        input logic [AW-1:0]            oreg,
        input logic [DW-1:0]            odat
    );
        logic          hit;
        logic [DW-1:0] d;
        logic [PW-1:0] idx;
        hit = 1'b0;
        d   = {DW{1'b0}};
        idx = {PW{1'b0}};
        if ((addr != {AW{1'b0}}) && ow && (oreg == addr)) begin
            hit = 1'b1;
            d   = odat;
        end else begin
            hit = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp + PW'(i);
            if ((addr != {AW{1'b0}}) && (CW'(i) < cnt) && (regs[idx] == addr)) begin
                hit = 1'b1;
                d   = dats[idx];
            end else begin
                hit = hit;
            end
        end
        return {hit, d};
    endfunction

    assign in_ready  = Rst & (r_count <= CW'(DEPTH - 2));
    assign w_alu_en  = alu_valid & in_ready & (alu_reg != {AW{1'b0}});
    assign w_ld_en   = ld_valid  & in_ready & (ld_reg  != {AW{1'b0}});
    assign w_enq_cnt = CW'(w_alu_en) + CW'(w_ld_en);
    assign w_ld_ptr  = r_wp + PW'(w_alu_en);
    assign w_pop     = (r_count != {CW{1'b0}});

    // Queue storage; ALU entry takes the older slot when both producers write.
    always_ff @(posedge btn) begin
        if (w_alu_en) begin
            r_reg_q[r_wp] <= alu_reg;
            r_dat_q[r_wp] <= alu_dat;
        end
        if (w_ld_en) begin
            r_reg_q[w_ld_ptr] <= ld_reg;
            r_dat_q[w_ld_ptr] <= ld_dat;
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge btn) begin
        if (!Rst) begin
            r_count    <= {CW{1'b0}};
            r_rp       <= {PW{1'b0}};
            r_wp       <= {PW{1'b0}};
            r_regwrite <= 1'b0;
            r_regw     <= {AW{1'b0}};
            r_wdat     <= {DW{1'b0}};
        end else begin
            r_count <= r_count + w_enq_cnt - CW'(w_pop);
            r_wp    <= r_wp + PW'(w_enq_cnt);
            if (w_pop) begin
                r_regwrite <= 1'b1;
                r_regw     <= r_reg_q[r_rp];
                r_wdat     <= r_dat_q[r_rp];
                r_rp       <= r_rp + PW'(1);
            end else begin
                r_regwrite <= 1'b0;
            end
        end
    end

    assign RegWrite = r_regwrite;
    assign regW     = r_regw;
    assign Wdat     = r_wdat;

    assign w_fa = fwd_lookup(regA, r_reg_q, r_dat_q, r_rp, r_count, r_regwrite, r_regw, r_wdat);
    assign w_fb = fwd_lookup(regB, r_reg_q, r_dat_q, r_rp, r_count, r_regwrite, r_regw, r_wdat);
    assign w_fc = fwd_lookup(regC, r_reg_q, r_dat_q, r_rp, r_count, r_regwrite, r_regw, r_wdat);

    assign hitA = w_fa[DW];
    assign fwdA = w_fa[DW-1:0];
    assign hitB = w_fb[DW];
    assign fwdB = w_fb[DW-1:0];
    assign hitC = w_fc[DW];
    assign fwdC = w_fc[DW-1:0];

endmodule
